// File: rtl/cm_loop_sched_if.sv
// Handshake/bus bundle for the cm_loop_sched three-deep loop-nest scheduler.
// Optional O_cycles member exists only when CM_LOOP_SCHED_STAT_EN is defined.
interface cm_loop_sched_if #(
    parameter int unsigned C_WIDTH = 8
);
    localparam int unsigned CNT_W = 32;

    logic               I_start;
    logic [C_WIDTH-1:0] I_upper0;
    logic [C_WIDTH-1:0] I_upper1;
    logic [C_WIDTH-1:0] I_upper2;
    logic               I_rdy;
    logic               O_busy;
    logic               O_valid;
    logic [C_WIDTH-1:0] O_idx0;
    logic [C_WIDTH-1:0] O_idx1;
    logic [C_WIDTH-1:0] O_idx2;
    logic               O_last0;
    logic               O_last;
    logic               O_done;
`ifdef CM_LOOP_SCHED_STAT_EN
    logic [CNT_W-1:0]   O_cycles;
`endif

    // Requester side: issues starts/bounds and the downstream ready
    modport master (
        output I_start, I_upper0, I_upper1, I_upper2, I_rdy,
        input  O_busy, O_valid, O_idx0, O_idx1, O_idx2, O_last0, O_last, O_done
`ifdef CM_LOOP_SCHED_STAT_EN
        , input O_cycles
`endif
    );

    // Scheduler side
    modport slave (
        input  I_start, I_upper0, I_upper1, I_upper2, I_rdy,
        output O_busy, O_valid, O_idx0, O_idx1, O_idx2, O_last0, O_last, O_done
`ifdef CM_LOOP_SCHED_STAT_EN
        , output O_cycles
`endif
    );
endinterface

// File: rtl/cm_loop_sched.sv
// cm_loop_sched: generates row-major (idx0 fastest) index sets for a
// three-deep loop nest under a valid/ready handshake.
// Optional RUN-cycle counter O_cycles: define CM_LOOP_SCHED_STAT_EN.
module cm_loop_sched #(
    parameter int unsigned C_WIDTH = 8
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    cm_loop_sched_if.slave lp
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [C_WIDTH-1:0] bnd0_q, bnd1_q, bnd2_q;
    logic [C_WIDTH-1:0] idx0_q, idx1_q, idx2_q;
    logic [C_WIDTH-1:0] idx0_d, idx1_d, idx2_d;
    logic               busy_q, valid_q, done_q;
    logic               wrap0_c, wrap1_c, wrap2_c, all_wrap_c;
    logic               xfer_c, start_ok_c;

    // A zero bound is treated as one iteration
    function automatic logic [C_WIDTH-1:0] fix_bound(input logic [C_WIDTH-1:0] b);
        return (b == '0) ? C_WIDTH'(1) : b;
    endfunction

    // Wrap detection and handshake qualifiers
    assign wrap0_c    = (idx0_q == (bnd0_q - C_WIDTH'(1)));
    assign wrap1_c    = (idx1_q == (bnd1_q - C_WIDTH'(1)));
    assign wrap2_c    = (idx2_q == (bnd2_q - C_WIDTH'(1)));
    assign all_wrap_c = wrap0_c & wrap1_c & wrap2_c;
    assign xfer_c     = valid_q & lp.I_rdy;
    assign start_ok_c = (state_q == ST_IDLE) & lp.I_start;

    // Next index set: odometer step on each transfer, all-wrap returns to zero
    always_comb begin
        idx0_d = idx0_q;
        idx1_d = idx1_q;
        idx2_d = idx2_q;
        if (xfer_c) begin
            idx0_d = wrap0_c ? '0 : idx0_q + C_WIDTH'(1);
            if (wrap0_c) begin
                idx1_d = wrap1_c ? '0 : idx1_q + C_WIDTH'(1);
                if (wrap1_c) begin
                    idx2_d = wrap2_c ? '0 : idx2_q + C_WIDTH'(1);
                end
            end
        end
    end

    // Control FSM with registered busy/valid/done and bound latches
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            bnd0_q  <= C_WIDTH'(1);
            bnd1_q  <= C_WIDTH'(1);
            bnd2_q  <= C_WIDTH'(1);
            idx0_q  <= '0;
            idx1_q  <= '0;
            idx2_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            idx0_q <= idx0_d;
            idx1_q <= idx1_d;
            idx2_q <= idx2_d;
            case (state_q)
                ST_IDLE: begin
                    if (lp.I_start) begin
                        bnd0_q  <= fix_bound(lp.I_upper0);
                        bnd1_q  <= fix_bound(lp.I_upper1);
                        bnd2_q  <= fix_bound(lp.I_upper2);
                        idx0_q  <= '0;
                        idx1_q  <= '0;
                        idx2_q  <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (xfer_c && all_wrap_c) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lp.O_busy  = busy_q;
    assign lp.O_valid = valid_q;
    assign lp.O_done  = done_q;
    assign lp.O_idx0  = idx0_q;
    assign lp.O_idx1  = idx1_q;
    assign lp.O_idx2  = idx2_q;
    assign lp.O_last0 = valid_q & wrap0_c;
    assign lp.O_last  = valid_q & all_wrap_c;

`ifdef CM_LOOP_SCHED_STAT_EN
    localparam int unsigned CNT_W = 32;
    logic [CNT_W-1:0] cycles_q;

    // Saturating RUN-cycle counter, cleared on an accepted start
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cycles_q <= '0;
        end else if (start_ok_c) begin
            cycles_q <= '0;
        end else if ((state_q == ST_RUN) && (cycles_q != '1)) begin
            cycles_q <= cycles_q + CNT_W'(1);
        end
    end

    assign lp.O_cycles = cycles_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok_c;
`endif

endmodule

// File: tb/tb_cm_loop_sched.sv
// Directed self-checking bench for cm_loop_sched.
// O_cycles checks are compiled in when CM_LOOP_SCHED_STAT_EN is defined.
module tb_cm_loop_sched;
    localparam int unsigned W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    cm_loop_sched_if #(.C_WIDTH(W)) lp ();

    cm_loop_sched #(.C_WIDTH(W)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .lp      (lp.slave)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start, then scramble the bounds (don't-care after latch)
    task automatic do_start(input int b0, input int b1, input int b2);
        lp.I_start  = 1'b1;
        lp.I_upper0 = W'(b0);
        lp.I_upper1 = W'(b1);
        lp.I_upper2 = W'(b2);
        tick();
        lp.I_start  = 1'b0;
        lp.I_upper0 = W'($urandom);
        lp.I_upper1 = W'($urandom);
        lp.I_upper2 = W'($urandom);
        chk("start_valid", 32'(lp.O_valid), 1);
        chk("start_busy",  32'(lp.O_busy), 1);
    endtask

    // Walk one run, checking every index set against a reference odometer
    task automatic run_nest(input int b0, input int b1, input int b2, input bit stall,
                            input int abort_at, input bit poke_start, input int exp_xfers);
        int eb0, eb1, eb2, e0, e1, e2, xfers, rc, budget;
        bit rdy, ended;
        eb0 = (b0 == 0) ? 1 : b0;
        eb1 = (b1 == 0) ? 1 : b1;
        eb2 = (b2 == 0) ? 1 : b2;
        e0 = 0; e1 = 0; e2 = 0; xfers = 0; rc = 0; ended = 1'b0;
        budget = 4 * eb0 * eb1 * eb2 + 20;
        for (int cyc = 0; cyc < budget && !ended; cyc++) begin
            if (abort_at >= 0 && xfers == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", 32'(lp.O_valid), 0);
                chk("rst_busy",  32'(lp.O_busy), 0);
                chk("rst_idx0",  32'(lp.O_idx0), 0);
                chk("rst_idx1",  32'(lp.O_idx1), 0);
                chk("rst_idx2",  32'(lp.O_idx2), 0);
                chk("rst_last0", 32'(lp.O_last0), 0);
`ifdef CM_LOOP_SCHED_STAT_EN
                chk("rst_cycles", lp.O_cycles, 0);
`endif
                lp.I_rdy = 1'b0;
                tick();
                chk("rst_no_done", 32'(lp.O_done), 0);
                rst_n = 1'b1;
                tick();
                chk("post_rst_done", 32'(lp.O_done), 0);
                chk("post_rst_busy", 32'(lp.O_busy), 0);
                ended = 1'b1;
            end else if (lp.O_done) begin
                ended = 1'b1;
            end else if (!lp.O_valid) begin
                chk("valid_drop", 32'(lp.O_valid), 1);
                ended = 1'b1;
            end else begin
                rc++;
                chk("run_busy", 32'(lp.O_busy), 1);
                chk("idx0", 32'(lp.O_idx0), 32'(e0));
                chk("idx1", 32'(lp.O_idx1), 32'(e1));
                chk("idx2", 32'(lp.O_idx2), 32'(e2));
                chk("last0", 32'(lp.O_last0), 32'(e0 == eb0 - 1));
                chk("last", 32'(lp.O_last),
                    32'((e0 == eb0 - 1) && (e1 == eb1 - 1) && (e2 == eb2 - 1)));
                rdy = stall ? ((rc % 2) == 0) : 1'b1;
                lp.I_rdy = rdy;
                if (poke_start && rc == 5) begin
                    lp.I_start  = 1'b1;
                    lp.I_upper0 = W'(2);
                    lp.I_upper1 = W'(2);
                    lp.I_upper2 = W'(2);
                end
                tick();
                lp.I_start = 1'b0;
                if (rdy) begin
                    xfers++;
                    if (e0 == eb0 - 1) begin
                        e0 = 0;
                        if (e1 == eb1 - 1) begin
                            e1 = 0;
                            e2 = (e2 == eb2 - 1) ? 0 : e2 + 1;
                        end else begin
                            e1++;
                        end
                    end else begin
                        e0++;
                    end
                end
            end
        end
        chk("run_ended", 32'(ended), 1);
        chk("xfers", 32'(xfers), 32'(exp_xfers));
        if (abort_at < 0) begin
            chk("done_pulse", 32'(lp.O_done), 1);
            chk("done_valid", 32'(lp.O_valid), 0);
            chk("done_busy",  32'(lp.O_busy), 1);
            chk("done_idx0",  32'(lp.O_idx0), 0);
            chk("done_idx1",  32'(lp.O_idx1), 0);
            chk("done_idx2",  32'(lp.O_idx2), 0);
`ifdef CM_LOOP_SCHED_STAT_EN
            chk("done_cycles", lp.O_cycles, 32'(rc));
`endif
        end
    endtask

    // Step from DONE into IDLE and check the pulse ended and the counter held
    task automatic finish_idle(input int exp_cycles);
        tick();
        chk("idle_done",  32'(lp.O_done), 0);
        chk("idle_busy",  32'(lp.O_busy), 0);
        chk("idle_valid", 32'(lp.O_valid), 0);
`ifdef CM_LOOP_SCHED_STAT_EN
        chk("idle_cycles", lp.O_cycles, 32'(exp_cycles));
`else
        if (exp_cycles < 0) chk("idle_cycles_arg", 32'(exp_cycles), 0);
`endif
    endtask

    initial begin
        lp.I_start  = 1'b0;
        lp.I_upper0 = '0;
        lp.I_upper1 = '0;
        lp.I_upper2 = '0;
        lp.I_rdy    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("reset_busy",  32'(lp.O_busy), 0);
        chk("reset_valid", 32'(lp.O_valid), 0);
        chk("reset_done",  32'(lp.O_done), 0);
        chk("reset_idx0",  32'(lp.O_idx0), 0);
        chk("reset_idx1",  32'(lp.O_idx1), 0);
        chk("reset_idx2",  32'(lp.O_idx2), 0);
        chk("reset_last0", 32'(lp.O_last0), 0);
        chk("reset_last",  32'(lp.O_last), 0);
`ifdef CM_LOOP_SCHED_STAT_EN
        chk("reset_cycles", lp.O_cycles, 0);
`endif
        rst_n = 1'b1;
        tick();
        chk("idle_no_busy", 32'(lp.O_busy), 0);

        // (3,2,2) streaming: 12 back-to-back transfers, 12 RUN cycles
        do_start(3, 2, 2);
        run_nest(3, 2, 2, 1'b0, -1, 1'b0, 12);
        finish_idle(12);

        // (2,2,1) stalled on every odd RUN cycle: 4 transfers over 8 cycles
        do_start(2, 2, 1);
        run_nest(2, 2, 1, 1'b1, -1, 1'b0, 4);
        finish_idle(8);

        // (0,1,5): zero bound behaves as one
        do_start(0, 1, 5);
        run_nest(0, 1, 5, 1'b0, -1, 1'b0, 5);
        finish_idle(5);

        // (4,4,4) with a start poked mid-run: ignored, full 64 transfers
        do_start(4, 4, 4);
        run_nest(4, 4, 4, 1'b0, -1, 1'b1, 64);
        finish_idle(64);

        // (4,4,4) with a start poked mid-run, then reset at transfer 20
        do_start(4, 4, 4);
        run_nest(4, 4, 4, 1'b0, 20, 1'b1, 20);

        // Fresh start after the abort runs to completion
        do_start(4, 4, 4);
        run_nest(4, 4, 4, 1'b0, -1, 1'b0, 64);
        finish_idle(64);

        // (255,1,1): full 8-bit range on idx0
        do_start(255, 1, 1);
        run_nest(255, 1, 1, 1'b0, -1, 1'b0, 255);
        finish_idle(255);

        // Start in the DONE cycle is ignored; the next IDLE-cycle start is taken
        do_start(2, 1, 1);
        run_nest(2, 1, 1, 1'b0, -1, 1'b0, 2);
        lp.I_start  = 1'b1;
        lp.I_upper0 = W'(3);
        lp.I_upper1 = W'(1);
        lp.I_upper2 = W'(1);
        finish_idle(2);
        do_start(1, 3, 1);
        run_nest(1, 3, 1, 1'b0, -1, 1'b0, 3);
        finish_idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
